// File: rtl/rv_instr_encoder.sv
// rtl/rv_instr_encoder.sv - symbolic op to RV32I instruction word encoder with address counter
module rv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic [15:0] word_count,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {K_R, K_I, K_SH, K_S, K_B, K_U, K_J} kind_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUI = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  kind_t       kind;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  logic [31:0] enc_word;

  // Immediate range checks expressed as sign-extension / alignment tests
  logic imm12_ok, shamt_ok, br_ok, jal_ok, upper_ok;
  assign imm12_ok = (imm[31:11] == {21{imm[11]}});
  assign shamt_ok = (imm[31:5] == 27'd0);
  assign br_ok    = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign jal_ok   = (imm[31:20] == {12{imm[20]}}) && !imm[0];
  assign upper_ok = (imm[11:0] == 12'd0);

  assign in_ready = !out_valid || out_ready;

  wire accept    = in_valid && in_ready;
  wire handshake = out_valid && out_ready;

  // Decode op_sel into instruction format, opcode, funct fields and legality
  always_comb begin
    kind  = K_R;
    opc   = OPC_R;
    f3    = 3'b000;
    f7    = 7'd0;
    legal = 1'b0;
    case (op_sel)
      5'd0:  begin f3 = 3'b000; legal = 1'b1; end
      5'd1:  begin f3 = 3'b000; f7 = F7_ALT; legal = 1'b1; end
      5'd2:  begin f3 = 3'b001; legal = 1'b1; end
      5'd3:  begin f3 = 3'b010; legal = 1'b1; end
      5'd4:  begin f3 = 3'b100; legal = 1'b1; end
      5'd5:  begin f3 = 3'b101; legal = 1'b1; end
      5'd6:  begin f3 = 3'b101; f7 = F7_ALT; legal = 1'b1; end
      5'd7:  begin f3 = 3'b110; legal = 1'b1; end
      5'd8:  begin f3 = 3'b111; legal = 1'b1; end
      5'd9:  begin kind = K_I; opc = OPC_I; f3 = 3'b000; legal = imm12_ok; end
      5'd10: begin kind = K_I; opc = OPC_I; f3 = 3'b010; legal = imm12_ok; end
      5'd11: begin kind = K_I; opc = OPC_I; f3 = 3'b100; legal = imm12_ok; end
      5'd12: begin kind = K_I; opc = OPC_I; f3 = 3'b110; legal = imm12_ok; end
      5'd13: begin kind = K_I; opc = OPC_I; f3 = 3'b111; legal = imm12_ok; end
      5'd14: begin kind = K_SH; opc = OPC_I; f3 = 3'b001; legal = shamt_ok; end
      5'd15: begin kind = K_SH; opc = OPC_I; f3 = 3'b101; legal = shamt_ok; end
      5'd16: begin kind = K_SH; opc = OPC_I; f3 = 3'b101; f7 = F7_ALT; legal = shamt_ok; end
      5'd17: begin kind = K_I; opc = OPC_LW; f3 = 3'b010; legal = imm12_ok; end
      5'd18: begin kind = K_S; opc = OPC_SW; f3 = 3'b010; legal = imm12_ok; end
      5'd19: begin kind = K_B; opc = OPC_BR; f3 = 3'b000; legal = br_ok; end
      5'd20: begin kind = K_B; opc = OPC_BR; f3 = 3'b001; legal = br_ok; end
      5'd21: begin kind = K_B; opc = OPC_BR; f3 = 3'b100; legal = br_ok; end
      5'd22: begin kind = K_B; opc = OPC_BR; f3 = 3'b101; legal = br_ok; end
      5'd23: begin kind = K_B; opc = OPC_BR; f3 = 3'b110; legal = br_ok; end
      5'd24: begin kind = K_B; opc = OPC_BR; f3 = 3'b111; legal = br_ok; end
      5'd25: begin kind = K_U; opc = OPC_LUI; legal = upper_ok; end
      5'd26: begin kind = K_U; opc = OPC_AUI; legal = upper_ok; end
      5'd27: begin kind = K_J; opc = OPC_JAL; legal = jal_ok; end
      default: legal = 1'b0;
    endcase
  end

  // Pack fields into the 32-bit word according to the selected format
  always_comb begin
    enc_word = 32'd0;
    case (kind)
      K_R:  enc_word = {f7, rs2, rs1, f3, rd, opc};
      K_I:  enc_word = {imm[11:0], rs1, f3, rd, opc};
      K_SH: enc_word = {f7, imm[4:0], rs1, f3, rd, opc};
      K_S:  enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      K_B:  enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      K_U:  enc_word = {imm[31:12], rd, opc};
      K_J:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: enc_word = 32'd0;
    endcase
  end

  // Output stage, address counter and statistics; flush overrides everything but rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_word   <= 32'd0;
      out_addr   <= BASE_ADDR;
      err_pulse  <= 1'b0;
      word_count <= 16'd0;
      err_count  <= 8'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_addr  <= BASE_ADDR;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= accept && !legal;
      if (accept && !legal && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (handshake) begin
        out_addr   <= out_addr + ADDR_STEP;
        word_count <= word_count + 16'd1;
      end
      if (accept && legal) begin
        out_valid <= 1'b1;
        out_word  <= enc_word;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb/tb_rv_instr_encoder.sv - self-checking bench for rv_instr_encoder
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op_sel = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err_pulse;
  logic [15:0] word_count;
  logic [7:0]  err_count;

  int passed = 0;
  int total  = 0;

  rv_instr_encoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err_pulse(err_pulse), .word_count(word_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  localparam int F3_R[9]  = '{0, 0, 1, 2, 4, 5, 5, 6, 7};
  localparam int F3_I[5]  = '{0, 2, 4, 6, 7};
  localparam int F3_B[6]  = '{0, 1, 4, 5, 6, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [31:0] im);
    op_sel = op; rd = d; rs1 = a; rs2 = b; imm = im; in_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference encoder: field placement by integer arithmetic, legality by numeric range
  function automatic void ref_encode(input int op, input int d, input int a, input int b,
                                     input int im, output bit legal, output logic [31:0] w);
    int x;
    bit r12;
    x = 0;
    legal = 1'b0;
    r12 = (im >= -2048) && (im <= 2047);
    if (op <= 8) begin
      legal = 1'b1;
      x = (((op == 1) || (op == 6)) ? 32 : 0) << 25 | b << 20 | a << 15 | F3_R[op] << 12 | d << 7 | 51;
    end else if (op <= 13) begin
      legal = r12;
      x = (im & 4095) << 20 | a << 15 | F3_I[op - 9] << 12 | d << 7 | 19;
    end else if (op <= 16) begin
      legal = (im >= 0) && (im <= 31);
      x = ((op == 16) ? 32 : 0) << 25 | (im & 31) << 20 | a << 15 | ((op == 14) ? 1 : 5) << 12 | d << 7 | 19;
    end else if (op == 17) begin
      legal = r12;
      x = (im & 4095) << 20 | a << 15 | 2 << 12 | d << 7 | 3;
    end else if (op == 18) begin
      legal = r12;
      x = ((im >> 5) & 127) << 25 | b << 20 | a << 15 | 2 << 12 | (im & 31) << 7 | 35;
    end else if (op <= 24) begin
      legal = (im >= -4096) && (im <= 4094) && (im % 2 == 0);
      x = ((im >> 12) & 1) << 31 | ((im >> 5) & 63) << 25 | b << 20 | a << 15 |
          F3_B[op - 19] << 12 | ((im >> 1) & 15) << 8 | ((im >> 11) & 1) << 7 | 99;
    end else if (op <= 26) begin
      legal = (im % 4096) == 0;
      x = (im & 32'hFFFFF000) | d << 7 | ((op == 25) ? 55 : 23);
    end else if (op == 27) begin
      legal = (im >= -1048576) && (im <= 1048574) && (im % 2 == 0);
      x = ((im >> 20) & 1) << 31 | ((im >> 1) & 1023) << 21 | ((im >> 11) & 1) << 20 |
          ((im >> 12) & 255) << 12 | d << 7 | 111;
    end
    w = 32'(x);
  endfunction

  function automatic logic [31:0] rand_imm();
    int sel;
    int edges[17] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096,
                      -1048577, -1048576, 1048574, 1048575, 1048576, 31, 32, 0};
    sel = $urandom_range(0, 5);
    case (sel)
      0: return 32'($urandom_range(0, 80)) - 32'd40;
      1: return 32'(edges[$urandom_range(0, 16)]);
      2: return 32'($urandom);
      3: return 32'($urandom) & 32'hFFFFF000;
      4: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    logic [31:0] exp_addr;
    int nleg;
    int nill;
    logic [31:0] q_word[$];
    logic [31:0] q_exp;
    int hs;
    int errs;
    bit prev_rej;
    bit lg;
    logic [31:0] w;

    // Reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    tick();
    rst = 1'b0;

    // Table of hand-computed encodings and boundary legality
    vecs.push_back('{5'd0,  5'd3, 5'd1, 5'd2, 32'd0,          1'b1, 32'h002081B3});
    vecs.push_back('{5'd1,  5'd5, 5'd6, 5'd7, 32'd0,          1'b1, 32'h407302B3});
    vecs.push_back('{5'd9,  5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,   1'b1, 32'hFFF00093});
    vecs.push_back('{5'd19, 5'd0, 5'd1, 5'd2, 32'd8,          1'b1, 32'h00208463});
    vecs.push_back('{5'd27, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b1, 32'h001000EF});
    vecs.push_back('{5'd25, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h123452B7});
    vecs.push_back('{5'd18, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC,   1'b1, 32'hFE312E23});
    vecs.push_back('{5'd17, 5'd4, 5'd2, 5'd0, 32'd2047,       1'b1, 32'h7FF12203});
    vecs.push_back('{5'd14, 5'd1, 5'd1, 5'd0, 32'd31,         1'b1, 32'h01F09093});
    vecs.push_back('{5'd20, 5'd0, 5'd1, 5'd2, 32'hFFFFF000,   1'b1, 32'h80209063});
    vecs.push_back('{5'd6,  5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h403150B3});
    vecs.push_back('{5'd26, 5'd2, 5'd0, 5'd0, 32'hFFFFF000,   1'b1, 32'hFFFFF117});
    vecs.push_back('{5'd27, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE,   1'b1, 32'hFFFFF06F});
    vecs.push_back('{5'd9,  5'd1, 5'd0, 5'd0, 32'd2048,       1'b0, 32'h0});
    vecs.push_back('{5'd16, 5'd1, 5'd0, 5'd0, 32'd40,         1'b0, 32'h0});
    vecs.push_back('{5'd19, 5'd0, 5'd1, 5'd2, 32'd3,          1'b0, 32'h0});
    vecs.push_back('{5'd30, 5'd1, 5'd1, 5'd1, 32'd0,          1'b0, 32'h0});
    vecs.push_back('{5'd27, 5'd1, 5'd0, 5'd0, 32'd1048576,    1'b0, 32'h0});
    vecs.push_back('{5'd25, 5'd5, 5'd0, 5'd0, 32'h12345001,   1'b0, 32'h0});

    exp_addr = 32'd0; nleg = 0; nill = 0;
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].legal));
      chk($sformatf("vec%0d_err", i), 32'(err_pulse), 32'(!vecs[i].legal));
      if (vecs[i].legal) begin
        chk($sformatf("vec%0d_word", i), out_word, vecs[i].word);
        chk($sformatf("vec%0d_addr", i), out_addr, exp_addr);
        exp_addr += 32'd4;
        nleg++;
      end else begin
        nill++;
      end
      tick();
    end
    chk("tbl_word_count", 32'(word_count), 32'(nleg));
    chk("tbl_err_count", 32'(err_count), 32'(nill));
    chk("tbl_out_addr", out_addr, exp_addr);

    // Single ADD then handshake
    do_reset();
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("add_word", out_word, 32'h002081B3);
    chk("add_addr", out_addr, 32'd0);
    tick();
    chk("add_wc", 32'(word_count), 32'd1);
    chk("add_valid_after", 32'(out_valid), 32'd0);

    // Back-to-back SUB, ADDI with no bubble
    do_reset();
    send(5'd1, 5'd5, 5'd6, 5'd7, 32'd0);
    tick();
    chk("b2b_w0", out_word, 32'h407302B3);
    chk("b2b_a0", out_addr, 32'd0);
    chk("b2b_ready", 32'(in_ready), 32'd1);
    send(5'd9, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    tick();
    in_valid = 1'b0;
    chk("b2b_v1", 32'(out_valid), 32'd1);
    chk("b2b_w1", out_word, 32'hFFF00093);
    chk("b2b_a1", out_addr, 32'd4);
    tick();

    // Three rejected requests, then err_count saturation
    do_reset();
    send(5'd16, 5'd1, 5'd1, 5'd0, 32'd40);
    tick();
    chk("rej0_pulse", 32'(err_pulse), 32'd1);
    chk("rej0_valid", 32'(out_valid), 32'd0);
    send(5'd19, 5'd0, 5'd1, 5'd2, 32'd3);
    tick();
    chk("rej1_pulse", 32'(err_pulse), 32'd1);
    chk("rej1_valid", 32'(out_valid), 32'd0);
    send(5'd30, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    chk("rej2_pulse", 32'(err_pulse), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("rej_pulse_end", 32'(err_pulse), 32'd0);
    chk("rej_count", 32'(err_count), 32'd3);
    chk("rej_addr", out_addr, 32'd0);
    chk("rej_valid", 32'(out_valid), 32'd0);
    send(5'd31, 5'd0, 5'd0, 5'd0, 32'd0);
    for (int k = 0; k < 260; k++) tick();
    in_valid = 1'b0;
    tick();
    chk("err_sat", 32'(err_count), 32'd255);

    // Asynchronous reset while a word is held
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    send(5'd7, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_wc", 32'(word_count), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_word", out_word, 32'd0);
    chk("arst_addr", out_addr, 32'd0);
    chk("arst_wc", 32'(word_count), 32'd0);
    chk("arst_ec", 32'(err_count), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // Backpressure: held word and waiting second request
    do_reset();
    out_ready = 1'b0;
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    chk("stall_w0", out_word, 32'h002081B3);
    chk("stall_ready0", 32'(in_ready), 32'd0);
    send(5'd1, 5'd5, 5'd6, 5'd7, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_hold_word", out_word, 32'h002081B3);
      chk("stall_hold_addr", out_addr, 32'd0);
      chk("stall_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_ready1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("stall_w1", out_word, 32'h407302B3);
    chk("stall_a1", out_addr, 32'd4);
    tick();
    chk("stall_wc", 32'(word_count), 32'd2);
    chk("stall_valid_end", 32'(out_valid), 32'd0);

    // Flush with a held word at address 8, then a dropped request during flush
    do_reset();
    send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    send(5'd1, 5'd5, 5'd6, 5'd7, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    send(5'd25, 5'd5, 5'd0, 5'd0, 32'h12345000);
    tick();
    in_valid = 1'b0;
    chk("fl_held_addr", out_addr, 32'd8);
    chk("fl_held_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_addr", out_addr, 32'd0);
    chk("fl_wc_kept", 32'(word_count), 32'd2);
    out_ready = 1'b1;
    flush = 1'b1;
    send(5'd9, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_drop_valid", 32'(out_valid), 32'd0);
    chk("fl_drop_err", 32'(err_pulse), 32'd0);
    send(5'd19, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("fl_next_word", out_word, 32'h00208463);
    chk("fl_next_addr", out_addr, 32'd0);
    tick();

    // Randomized traffic against the reference encoder and scoreboard
    do_reset();
    hs = 0; errs = 0; prev_rej = 1'b0; exp_addr = 32'd0;
    for (int c = 0; c < 600; c++) begin
      if (c < 590) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        op_sel    = 5'($urandom_range(0, 31));
        rd        = 5'($urandom);
        rs1       = 5'($urandom);
        rs2       = 5'($urandom);
        imm       = rand_imm();
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #4;
      chk("rnd_valid", 32'(out_valid), 32'(q_word.size() != 0));
      chk("rnd_ready", 32'(in_ready), 32'((q_word.size() == 0) || out_ready));
      chk("rnd_err_pulse", 32'(err_pulse), 32'(prev_rej));
      prev_rej = 1'b0;
      if (out_valid && out_ready) begin
        if (q_word.size() == 0) begin
          chk("rnd_unexpected_word", 32'd1, 32'd0);
        end else begin
          q_exp = q_word.pop_front();
          chk("rnd_word", out_word, q_exp);
          chk("rnd_addr", out_addr, exp_addr);
        end
        exp_addr += 32'd4;
        hs++;
      end
      if (in_valid && ((q_word.size() == 0) || out_ready)) begin
        ref_encode(int'(op_sel), int'(rd), int'(rs1), int'(rs2), int'(imm), lg, w);
        if (lg) q_word.push_back(w);
        else begin
          errs++;
          prev_rej = 1'b1;
        end
      end
      tick();
    end
    chk("rnd_drained", 32'(q_word.size()), 32'd0);
    chk("rnd_word_count", 32'(word_count), 32'(hs[15:0]));
    chk("rnd_err_count", 32'(err_count), 32'((errs > 255) ? 255 : errs));
    chk("rnd_final_addr", out_addr, exp_addr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
